mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM stage between EXE and WB: accepts one load/store per handshake from EXE and drives a variable-latency data-memory request/ack port.
- Aligns, masks and sign/zero-extends load data.
- Presents load results to WB on from_mem / store_data_to / read_data as a registered one-cycle pulse.
- Stores produce no WB traffic.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for dmem_ack before aborting the access; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EXE presents an operation
- ex_ready  out  1  stage can accept; high only in IDLE
- ex_is_load  in  1  operation is a load
- ex_is_store  in  1  operation is a store; both load and store high = illegal
- ex_addr  in  32  byte address
- ex_store_data  in  32  store data, low-aligned
- ex_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- ex_unsigned  in  1  zero-extend load when 1
- ex_rd_addr  in  5  load destination register
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1=write
- dmem_addr  out  32  word address {ex_addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated write data
- dmem_ack  in  1  one-cycle completion; dmem_rdata valid with it
- dmem_rdata  in  32  read word
- from_mem  out  1  load result valid to WB, one-cycle pulse
- store_data_to  out  5  destination register for WB
- read_data  out  32  extended load data for WB
- mem_err  out  1  one-cycle pulse: misaligned/illegal access or timeout

Behaviour:
- Reset (async, immediate): state=IDLE, ex_ready=1. All other outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, from_mem, store_data_to, read_data, mem_err. Timeout counter=0. Reset mid-access abandons the request; a late dmem_ack after reset is ignored.
- States: IDLE, REQ, RESP.
- IDLE: accept when ex_valid & ex_ready. Accepted op with neither load nor store: consumed, no action.
- Illegal access → mem_err pulses the next cycle, no request, stay IDLE. Illegal means any of:
  - ex_size=3
  - load and store both high
  - half with addr[0]=1
  - word with addr[1:0]≠0
- Legal load/store → REQ. Registered outputs:
  - dmem_req=1 and dmem_we=ex_is_store.
  - dmem_addr, dmem_be, dmem_wdata latched.
  - rd, size, unsigned and addr[1:0] held internally.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- Write data: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- REQ: all dmem_* outputs held stable until the ack cycle; counter increments each cycle.
- Ack cycle: dmem_ack=1 → dmem_req drops next cycle, counter cleared.
  - Store → IDLE.
  - Load → RESP.
- Load extraction: dmem_rdata >> (8*addr[1:0]); take low 8 or 16 bits; sign-extend unless ex_unsigned.
- Timeout: counter reaches TIMEOUT_CYCLES without ack → dmem_req=0, mem_err pulse, IDLE, no WB output.
- Ack and timeout in the same cycle: ack wins.
- RESP: exactly one cycle, then IDLE.
  - from_mem=1 only if store_data_to≠0.
  - store_data_to = latched rd; read_data = extended data.
- Outside RESP: from_mem=0; store_data_to/read_data hold their last values.
- Latency:
  - Load: accept cycle +1 = req; ack in cycle N → from_mem in cycle N+1.
  - Back-to-back throughput: one op per (2 + ack wait) cycles for stores, 3 + ack wait for loads.
- dmem_ack outside REQ is ignored.

Test Plan:
- Word load: addr=0x100, rd=5, ack after 2 cycles with rdata=0xDEADBEEF → dmem_be=1111, dmem_addr=0x100; from_mem=1 one cycle after ack with read_data=0xDEADBEEF, store_data_to=5.
- Byte loads, rdata=0x80FF7F01: addr=0x203 signed → 0xFFFFFF80; addr=0x202 unsigned → 0x000000FF; addr=0x201 signed → 0x0000007F; be=1000/0100/0010.
- Half store: addr=0x302, data=0x1234ABCD → dmem_we=1, be=1100, wdata=0xABCDABCD; no from_mem pulse; ex_ready returns high the cycle after ack.
- Misalignment: word at 0x102 → mem_err pulse, dmem_req never asserted, ex_ready stays 1. Half at 0x101 → same.
- Timeout: TIMEOUT_CYCLES=4, no ack → dmem_req high for 4 cycles then low, mem_err pulse, no from_mem. An ack landing on cycle 4 completes normally.
- Async reset asserted while in REQ → dmem_req=0 and ex_ready=1 immediately. A dmem_ack after release produces no from_mem. A load to rd=0 completes with from_mem=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one load/store per EXE handshake to a variable-latency
// data memory and returns aligned, extended load data to WB as a one-cycle pulse.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [4:0]  ex_rd_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        from_mem,
    output logic [4:0]  store_data_to,
    output logic [31:0] read_data,
    output logic        mem_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_req, w_req, r_we, w_we;
    logic [31:0] r_addr, w_addr, r_wdata, w_wdata;
    logic [3:0]  r_be, w_be;
    logic        r_from_mem, w_from_mem, r_err, w_err;
    logic [4:0]  r_rd_out, w_rd_out, r_rd, w_rd;
    logic [31:0] r_rdata_out, w_rdata_out;
    logic [1:0]  r_size, w_size, r_off, w_off;
    logic        r_uns, w_uns;
    logic        w_illegal;
    logic [31:0] w_shifted, w_ext;

    assign w_illegal = (ex_size == 2'd3) || (ex_is_load && ex_is_store) ||
                       (ex_size == 2'd1 && ex_addr[0]) ||
                       (ex_size == 2'd2 && ex_addr[1:0] != 2'b00);

    assign w_shifted = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shifted;
        case (r_size)
            2'd0:    w_ext = {{24{w_shifted[7] & ~r_uns}}, w_shifted[7:0]};
            2'd1:    w_ext = {{16{w_shifted[15] & ~r_uns}}, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_req       = r_req;
        w_we        = r_we;
        w_addr      = r_addr;
        w_be        = r_be;
        w_wdata     = r_wdata;
        w_from_mem  = 1'b0;
        w_err       = 1'b0;
        w_rd_out    = r_rd_out;
        w_rdata_out = r_rdata_out;
        w_rd        = r_rd;
        w_size      = r_size;
        w_off       = r_off;
        w_uns       = r_uns;
        case (r_state)
            ST_IDLE: begin
                if (ex_valid && (ex_is_load || ex_is_store)) begin
                    if (w_illegal) begin
                        w_err = 1'b1;
                    end else begin
                        w_state = ST_REQ;
                        w_req   = 1'b1;
                        w_we    = ex_is_store;
                        w_addr  = {ex_addr[31:2], 2'b00};
                        w_cnt   = '0;
                        w_rd    = ex_rd_addr;
                        w_size  = ex_size;
                        w_off   = ex_addr[1:0];
                        w_uns   = ex_unsigned;
                        case (ex_size)
                            2'd0: begin
                                w_be    = 4'b0001 << ex_addr[1:0];
                                w_wdata = {4{ex_store_data[7:0]}};
                            end
                            2'd1: begin
                                w_be    = 4'b0011 << ex_addr[1:0];
                                w_wdata = {2{ex_store_data[15:0]}};
                            end
                            default: begin
                                w_be    = 4'b1111;
                                w_wdata = ex_store_data;
                            end
                        endcase
                    end
                end
            end
            ST_REQ: begin
                // ack is checked first so an ack on the final wait cycle still completes
                if (dmem_ack) begin
                    w_req = 1'b0;
                    w_we  = 1'b0;
                    w_cnt = '0;
                    if (r_we) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_state     = ST_RESP;
                        w_from_mem  = (r_rd != 5'd0);
                        w_rd_out    = r_rd;
                        w_rdata_out = w_ext;
                    end
                end else if (r_cnt == LP_LAST) begin
                    w_req   = 1'b0;
                    w_we    = 1'b0;
                    w_cnt   = '0;
                    w_err   = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_RESP: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_from_mem  <= 1'b0;
            r_err       <= 1'b0;
            r_rd_out    <= '0;
            r_rdata_out <= '0;
            r_rd        <= '0;
            r_size      <= '0;
            r_off       <= '0;
            r_uns       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_req       <= w_req;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_from_mem  <= w_from_mem;
            r_err       <= w_err;
            r_rd_out    <= w_rd_out;
            r_rdata_out <= w_rdata_out;
            r_rd        <= w_rd;
            r_size      <= w_size;
            r_off       <= w_off;
            r_uns       <= w_uns;
        end
    end

    assign ex_ready      = (r_state == ST_IDLE);
    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_be       = r_be;
    assign dmem_wdata    = r_wdata;
    assign from_mem      = r_from_mem;
    assign store_data_to = r_rd_out;
    assign read_data     = r_rdata_out;
    assign mem_err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT_CYCLES=4; hand-computed expectations.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic        ex_is_load = 1'b0, ex_is_store = 1'b0;
    logic [31:0] ex_addr = '0, ex_store_data = '0;
    logic [1:0]  ex_size = '0;
    logic        ex_unsigned = 1'b0;
    logic [4:0]  ex_rd_addr = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        from_mem, mem_err;
    logic [4:0]  store_data_to;
    logic [31:0] read_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd_addr(ex_rd_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .from_mem(from_mem), .store_data_to(store_data_to),
        .read_data(read_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_addr = addr;
        ex_store_data = data; ex_size = size; ex_unsigned = uns; ex_rd_addr = rd;
        step();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdata);
        dmem_ack = 1'b1; dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
    endtask

    task automatic byte_load(input string tag, input logic [31:0] addr, input logic uns,
                             input logic [3:0] be, input logic [31:0] exp);
        issue(1'b1, 1'b0, addr, '0, 2'd0, uns, 5'd3);
        chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, be});
        chk({tag, "_addr"}, dmem_addr, 32'h200);
        ack(32'h80FF7F01);
        chk({tag, "_from"}, {31'd0, from_mem}, 32'd1);
        chk({tag, "_data"}, read_data, exp);
        step();
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        rst_n = 1'b1;
        step();

        // word load with two REQ cycles before ack
        issue(1'b1, 1'b0, 32'h100, '0, 2'd2, 1'b0, 5'd5);
        chk("wl_req", {31'd0, dmem_req}, 32'd1);
        chk("wl_we", {31'd0, dmem_we}, 32'd0);
        chk("wl_be", {28'd0, dmem_be}, 32'hF);
        chk("wl_addr", dmem_addr, 32'h100);
        chk("wl_ready", {31'd0, ex_ready}, 32'd0);
        step();
        chk("wl_req2", {31'd0, dmem_req}, 32'd1);
        chk("wl_nofrom", {31'd0, from_mem}, 32'd0);
        ack(32'hDEADBEEF);
        chk("wl_from", {31'd0, from_mem}, 32'd1);
        chk("wl_data", read_data, 32'hDEADBEEF);
        chk("wl_rd", {27'd0, store_data_to}, 32'd5);
        chk("wl_reqdrop", {31'd0, dmem_req}, 32'd0);
        step();
        chk("wl_pulse", {31'd0, from_mem}, 32'd0);
        chk("wl_idle", {31'd0, ex_ready}, 32'd1);
        chk("wl_hold", read_data, 32'hDEADBEEF);

        byte_load("b3s", 32'h203, 1'b0, 4'b1000, 32'hFFFFFF80);
        byte_load("b2u", 32'h202, 1'b1, 4'b0100, 32'h000000FF);
        byte_load("b1s", 32'h201, 1'b0, 4'b0010, 32'h0000007F);

        // half load, signed, upper lane
        issue(1'b1, 1'b0, 32'h202, '0, 2'd1, 1'b0, 5'd4);
        chk("hl_be", {28'd0, dmem_be}, 32'hC);
        ack(32'h80FF7F01);
        chk("hl_data", read_data, 32'hFFFF80FF);
        step();

        // half store
        issue(1'b0, 1'b1, 32'h302, 32'h1234ABCD, 2'd1, 1'b0, 5'd9);
        chk("hs_we", {31'd0, dmem_we}, 32'd1);
        chk("hs_be", {28'd0, dmem_be}, 32'hC);
        chk("hs_wdata", dmem_wdata, 32'hABCDABCD);
        chk("hs_addr", dmem_addr, 32'h300);
        ack(32'h0);
        chk("hs_ready", {31'd0, ex_ready}, 32'd1);
        chk("hs_nofrom", {31'd0, from_mem}, 32'd0);
        chk("hs_reqdrop", {31'd0, dmem_req}, 32'd0);
        chk("hs_rdhold", {27'd0, store_data_to}, 32'd4);

        // byte store lane replication
        issue(1'b0, 1'b1, 32'h305, 32'h000000A5, 2'd0, 1'b0, 5'd0);
        chk("bs_be", {28'd0, dmem_be}, 32'h2);
        chk("bs_wdata", dmem_wdata, 32'hA5A5A5A5);
        ack(32'h0);

        // illegal accesses
        issue(1'b1, 1'b0, 32'h102, '0, 2'd2, 1'b0, 5'd1);
        chk("mw_err", {31'd0, mem_err}, 32'd1);
        chk("mw_req", {31'd0, dmem_req}, 32'd0);
        chk("mw_ready", {31'd0, ex_ready}, 32'd1);
        step();
        chk("mw_pulse", {31'd0, mem_err}, 32'd0);
        chk("mw_req2", {31'd0, dmem_req}, 32'd0);
        issue(1'b1, 1'b0, 32'h101, '0, 2'd1, 1'b0, 5'd1);
        chk("mh_err", {31'd0, mem_err}, 32'd1);
        chk("mh_req", {31'd0, dmem_req}, 32'd0);
        step();
        issue(1'b1, 1'b0, 32'h100, '0, 2'd3, 1'b0, 5'd1);
        chk("sz3_err", {31'd0, mem_err}, 32'd1);
        step();
        issue(1'b1, 1'b1, 32'h100, '0, 2'd2, 1'b0, 5'd1);
        chk("both_err", {31'd0, mem_err}, 32'd1);
        chk("both_req", {31'd0, dmem_req}, 32'd0);
        step();
        issue(1'b0, 1'b0, 32'h100, '0, 2'd2, 1'b0, 5'd1);
        chk("nop_req", {31'd0, dmem_req}, 32'd0);
        chk("nop_err", {31'd0, mem_err}, 32'd0);
        chk("nop_ready", {31'd0, ex_ready}, 32'd1);

        // timeout after 4 REQ cycles
        issue(1'b1, 1'b0, 32'h400, '0, 2'd2, 1'b0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            chk("to_reqhigh", {31'd0, dmem_req}, 32'd1);
            step();
        end
        chk("to_req4", {31'd0, dmem_req}, 32'd1);
        chk("to_noerr", {31'd0, mem_err}, 32'd0);
        step();
        chk("to_reqlow", {31'd0, dmem_req}, 32'd0);
        chk("to_err", {31'd0, mem_err}, 32'd1);
        chk("to_nofrom", {31'd0, from_mem}, 32'd0);
        chk("to_ready", {31'd0, ex_ready}, 32'd1);
        step();
        chk("to_pulse", {31'd0, mem_err}, 32'd0);

        // ack on the fourth REQ cycle wins over timeout
        issue(1'b1, 1'b0, 32'h400, '0, 2'd2, 1'b0, 5'd7);
        step(); step(); step();
        ack(32'h11223344);
        chk("ta_from", {31'd0, from_mem}, 32'd1);
        chk("ta_err", {31'd0, mem_err}, 32'd0);
        chk("ta_data", read_data, 32'h11223344);
        chk("ta_rd", {27'd0, store_data_to}, 32'd7);
        step();

        // async reset during REQ
        issue(1'b1, 1'b0, 32'h500, '0, 2'd2, 1'b0, 5'd6);
        chk("ar_req", {31'd0, dmem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_reqlow", {31'd0, dmem_req}, 32'd0);
        chk("ar_ready", {31'd0, ex_ready}, 32'd1);
        chk("ar_rd", {27'd0, store_data_to}, 32'd0);
        #1 rst_n = 1'b1;
        step();
        ack(32'hCAFEF00D);
        chk("ar_lateack", {31'd0, from_mem}, 32'd0);
        chk("ar_latereq", {31'd0, dmem_req}, 32'd0);
        step();
        chk("ar_late2", {31'd0, from_mem}, 32'd0);
        chk("ar_data", read_data, 32'd0);

        // load to x0 completes without a WB pulse
        issue(1'b1, 1'b0, 32'h600, '0, 2'd2, 1'b0, 5'd0);
        ack(32'h55AA55AA);
        chk("r0_from", {31'd0, from_mem}, 32'd0);
        chk("r0_busy", {31'd0, ex_ready}, 32'd0);
        chk("r0_data", read_data, 32'h55AA55AA);
        step();
        chk("r0_idle", {31'd0, ex_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
